// File: rtl/axi_sram_slave_pkg.sv
// Shared burst/response encodings, FSM state type and AXI address-sequencing helpers
// for the single-port SRAM responder.
package axi_sram_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_WR_RESP
   } state_t;

   // A burst is unserviceable as a whole: oversize beats, reserved type or illegal wrap length.
   function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      logic bad_wrap;
      bad_wrap  = (burst == BURST_WRAP) &&
                  !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      burst_err = (size > 3'd2) || (burst == 2'b11) || bad_wrap;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] bytes;
      logic [31:0] win_mask;
      logic [31:0] aligned;
      bytes    = 32'd1 << size;
      aligned  = addr & ~(bytes - 32'd1);
      win_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~win_mask) | ((addr + bytes) & win_mask);
         // Aligning first makes an unaligned INCR start land on size boundaries afterwards.
         default:     next_addr = aligned + bytes;
      endcase
   endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// Single-port DEPTH x 32 SRAM with byte-enable writes and a one-cycle registered read;
// the read register only updates on a read access, so it holds its value otherwise.
module sram_sp #(
   parameter int DEPTH     = 4096,
   parameter     INIT_FILE = ""
) (
   input  logic                     clock,
   input  logic                     i_en,
   input  logic                     i_we,
   input  logic [3:0]               i_be,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [31:0]              i_wdata,
   output logic [31:0]              o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clock) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < 4; b++) begin
               if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder over a single-port SRAM, one transaction at a time; first R beat 2 cycles
// after AR, 1 beat per 2 cycles, W accepted every cycle; valids hold until their handshake.
module axi_sram_slave
   import axi_sram_slave_pkg::*;
#(
   parameter int ID_WIDTH    = 4,
   parameter int DEPTH_WORDS = 4096,
   parameter     INIT_FILE   = ""
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ID_WIDTH-1:0] io_axi_ar_bits_id,
   input  logic [31:0]         io_axi_ar_bits_addr,
   input  logic [7:0]          io_axi_ar_bits_len,
   input  logic [2:0]          io_axi_ar_bits_size,
   input  logic [1:0]          io_axi_ar_bits_burst,
   input  logic                io_axi_ar_valid,
   output logic                io_axi_ar_ready,
   output logic [ID_WIDTH-1:0] io_axi_r_bits_id,
   output logic [31:0]         io_axi_r_bits_data,
   output logic [1:0]          io_axi_r_bits_resp,
   output logic                io_axi_r_bits_last,
   output logic                io_axi_r_valid,
   input  logic                io_axi_r_ready,
   input  logic [ID_WIDTH-1:0] io_axi_aw_bits_id,
   input  logic [31:0]         io_axi_aw_bits_addr,
   input  logic [7:0]          io_axi_aw_bits_len,
   input  logic [2:0]          io_axi_aw_bits_size,
   input  logic [1:0]          io_axi_aw_bits_burst,
   input  logic                io_axi_aw_valid,
   output logic                io_axi_aw_ready,
   input  logic [31:0]         io_axi_w_bits_data,
   input  logic [3:0]          io_axi_w_bits_strb,
   input  logic                io_axi_w_bits_last,
   input  logic                io_axi_w_valid,
   output logic                io_axi_w_ready,
   output logic [ID_WIDTH-1:0] io_axi_b_bits_id,
   output logic [1:0]          io_axi_b_bits_resp,
   output logic                io_axi_b_valid,
   input  logic                io_axi_b_ready
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rd_prio;
   logic [ID_WIDTH-1:0] r_id;
   logic [31:0]         r_addr;
   logic [7:0]          r_len;
   logic [7:0]          r_beat_cnt;
   logic [2:0]          r_size;
   logic [1:0]          r_burst;
   logic                r_err;

   logic                w_ar_ready;
   logic                w_aw_ready;
   logic                w_w_ready;
   logic                w_r_valid;
   logic                w_b_valid;
   logic                w_last_beat;
   logic                w_field_err;
   logic                w_r_hs;
   logic                w_w_hs;
   logic                w_sram_en;
   logic                w_sram_we;
   logic [31:0]         w_sram_q;

   assign w_last_beat = (r_beat_cnt == r_len);
   assign w_field_err = burst_err(r_len, r_size, r_burst);
   assign w_r_hs      = w_r_valid & io_axi_r_ready;
   assign w_w_hs      = w_w_ready & io_axi_w_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_ar_ready  = 1'b0;
      w_aw_ready  = 1'b0;
      w_w_ready   = 1'b0;
      w_r_valid   = 1'b0;
      w_b_valid   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // rd_prio breaks ties only; a lone request is always granted.
            w_ar_ready = ~reset & io_axi_ar_valid & (~io_axi_aw_valid | r_rd_prio);
            w_aw_ready = ~reset & io_axi_aw_valid & (~io_axi_ar_valid | ~r_rd_prio);
            if (w_ar_ready)      w_state_nxt = ST_RD_ADDR;
            else if (w_aw_ready) w_state_nxt = ST_WR_DATA;
         end
         ST_RD_ADDR: w_state_nxt = ST_RD_DATA;
         ST_RD_DATA: begin
            w_r_valid = 1'b1;
            if (io_axi_r_ready) w_state_nxt = w_last_beat ? ST_IDLE : ST_RD_ADDR;
         end
         ST_WR_DATA: begin
            w_w_ready = 1'b1;
            if (io_axi_w_valid && w_last_beat) w_state_nxt = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            w_b_valid = 1'b1;
            if (io_axi_b_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_rd_prio  <= 1'b1;
         r_beat_cnt <= 8'd0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ar_ready) begin
            r_id       <= io_axi_ar_bits_id;
            r_addr     <= io_axi_ar_bits_addr;
            r_len      <= io_axi_ar_bits_len;
            r_size     <= io_axi_ar_bits_size;
            r_burst    <= io_axi_ar_bits_burst;
            r_beat_cnt <= 8'd0;
            r_rd_prio  <= 1'b0;
         end else if (w_aw_ready) begin
            r_id       <= io_axi_aw_bits_id;
            r_addr     <= io_axi_aw_bits_addr;
            r_len      <= io_axi_aw_bits_len;
            r_size     <= io_axi_aw_bits_size;
            r_burst    <= io_axi_aw_bits_burst;
            r_beat_cnt <= 8'd0;
            r_err      <= 1'b0;
            r_rd_prio  <= 1'b1;
         end
         if ((w_r_hs || w_w_hs) && !w_last_beat) begin
            r_addr     <= next_addr(r_addr, r_len, r_size, r_burst);
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end
         // The beat count, not wlast, ends the burst; a misplaced wlast only poisons the response.
         if (w_w_hs && (io_axi_w_bits_last != w_last_beat)) r_err <= 1'b1;
      end
   end

   assign w_sram_en = (r_state == ST_RD_ADDR) | (w_w_hs & ~w_field_err);
   assign w_sram_we = (r_state == ST_WR_DATA);

   sram_sp #(
      .DEPTH     (DEPTH_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_sram (
      .clock   (clock),
      .i_en    (w_sram_en),
      .i_we    (w_sram_we),
      .i_be    (io_axi_w_bits_strb),
      .i_addr  (r_addr[IDX_W+1:2]),
      .i_wdata (io_axi_w_bits_data),
      .o_rdata (w_sram_q)
   );

   assign io_axi_ar_ready    = w_ar_ready;
   assign io_axi_aw_ready    = w_aw_ready;
   assign io_axi_w_ready     = w_w_ready;
   assign io_axi_r_valid     = w_r_valid;
   assign io_axi_r_bits_id   = r_id;
   assign io_axi_r_bits_data = (w_r_valid && !w_field_err) ? w_sram_q : 32'd0;
   assign io_axi_r_bits_resp = (w_r_valid && w_field_err) ? RESP_SLVERR : RESP_OKAY;
   assign io_axi_r_bits_last = w_r_valid & w_last_beat;
   assign io_axi_b_valid     = w_b_valid;
   assign io_axi_b_bits_id   = r_id;
   assign io_axi_b_bits_resp = (w_b_valid && (r_err || w_field_err)) ? RESP_SLVERR : RESP_OKAY;

endmodule
